// File: rtl/dct_transpose.sv
// Ping-pong 8x8 transpose buffer between the row and column 1D-DCT passes.
// Takes one coefficient per beat in row-major order. Emits one packed column per beat:
// lane k of the output word holds block row k.
module dct_transpose #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    // row-pass coefficient stream
    input  logic                    i_coef_tvalid,
    output logic                    o_coef_tready,
    input  logic [DATA_WIDTH-1:0]   i_coef_tdata,
    input  logic                    i_coef_tlast,
    input  logic                    i_coef_tuser,
    // column word stream
    output logic                    o_col_tvalid,
    input  logic                    i_col_tready,
    output logic [8*DATA_WIDTH-1:0] o_col_tdata,
    output logic                    o_col_tlast,
    output logic                    o_col_tuser,
    output logic [DATA_WIDTH-1:0]   o_col_tkeep,
    output logic [DATA_WIDTH-1:0]   o_col_tstrb
);

    // Two 64-entry banks; contents are never reset, only the flags guarding them.
    logic [DATA_WIDTH-1:0] r_bank [2][64];

    logic [1:0]              r_full;
    logic [1:0]              r_sof;
    logic [1:0]              r_eob;
    logic                    r_wr_bank;
    logic [5:0]              r_wr_cnt;
    logic                    r_rd_bank;
    logic [2:0]              r_rd_col;

    logic                    r_tvalid;
    logic [8*DATA_WIDTH-1:0] r_tdata;
    logic                    r_tlast;
    logic                    r_tuser;

    logic                    w_wr_hs;
    logic                    w_resync;
    logic [5:0]              w_wr_addr;
    logic                    w_blk_done;
    logic                    w_rd_adv;
    logic                    w_load;
    logic                    w_rd_done;
    logic [1:0]              w_full_nxt;
    logic [8*DATA_WIDTH-1:0] w_col;

    // tready comes straight from a registered flag, so no path from the output side.
    assign o_coef_tready = !r_full[r_wr_bank];
    assign w_wr_hs       = i_coef_tvalid && o_coef_tready;
    // tuser mid-block restarts the block in the same bank at entry 0.
    assign w_resync      = w_wr_hs && i_coef_tuser && (r_wr_cnt != 6'd0);
    assign w_wr_addr     = w_resync ? 6'd0 : r_wr_cnt;
    assign w_blk_done    = w_wr_hs && !w_resync && (r_wr_cnt == 6'd63);

    assign w_rd_adv      = !r_tvalid || i_col_tready;
    assign w_load        = w_rd_adv && r_full[r_rd_bank];
    assign w_rd_done     = w_load && (r_rd_col == 3'd7);

    assign o_col_tvalid  = r_tvalid;
    assign o_col_tdata   = r_tdata;
    assign o_col_tlast   = r_tlast;
    assign o_col_tuser   = r_tuser;
    assign o_col_tkeep   = '1;
    assign o_col_tstrb   = '1;

    // Full flags: the reader's bank may clear while the writer's bank sets in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_blk_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // Gather column rd_col of the read bank; lane k is row k.
    always_comb begin
        w_col = '0;
        for (int k = 0; k < 8; k++) begin
            w_col[k*DATA_WIDTH +: DATA_WIDTH] = r_bank[r_rd_bank][{3'(k), r_rd_col}];
        end
    end

    // Coefficient storage write port.
    always_ff @(posedge clk_i) begin
        if (w_wr_hs) begin
            r_bank[r_wr_bank][w_wr_addr] <= i_coef_tdata;
        end
    end

    // Write-side pointers and per-bank sof/eob flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_full    <= '0;
            r_sof     <= '0;
            r_eob     <= '0;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_resync) begin
                r_sof[r_wr_bank] <= 1'b1;
                r_wr_cnt         <= 6'd1;
            end else if (w_wr_hs) begin
                if (r_wr_cnt == 6'd0) begin
                    r_sof[r_wr_bank] <= i_coef_tuser;
                end
                if (r_wr_cnt == 6'd63) begin
                    r_eob[r_wr_bank] <= i_coef_tlast;
                    r_wr_bank        <= !r_wr_bank;
                end
                r_wr_cnt <= r_wr_cnt + 6'd1;
            end
        end
    end

    // Read-side pointers and the output register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_bank <= 1'b0;
            r_rd_col  <= '0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tlast   <= 1'b0;
            r_tuser   <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_col;
            r_tuser  <= r_sof[r_rd_bank] && (r_rd_col == 3'd0);
            r_tlast  <= r_eob[r_rd_bank] && (r_rd_col == 3'd7);
            r_rd_col <= r_rd_col + 3'd1;
            if (w_rd_done) begin
                r_rd_bank <= !r_rd_bank;
            end
        end else if (w_rd_adv) begin
            // nothing to send: drop valid, hold payload
            r_tvalid <= 1'b0;
        end
    end

endmodule
